// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the cart/USB memory arbiter: access width codes,
// FSM states and requester identifiers.
package mem_arbiter_pkg;

    localparam logic [1:0] DATA_WIDTH_0  = 2'b00;
    localparam logic [1:0] DATA_WIDTH_8  = 2'b01;
    localparam logic [1:0] DATA_WIDTH_16 = 2'b10;
    localparam logic [1:0] DATA_WIDTH_32 = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RD_WAIT = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_CART = 1'b0,
        REQ_USB  = 1'b1
    } req_id_e;

endpackage

// File: rtl/mem_arbiter_starve_counter.sv
// Saturating count of consecutive arbitration cycles in which a pending USB
// request was passed over. Saturation is what forces USB ahead of the cart.
module arb_starve_counter #(
    parameter int unsigned LIMIT = 8,
    parameter int unsigned CW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc_i,
    input  logic          clr_i,
    output logic [CW-1:0] cnt_o,
    output logic          sat_o
);

    logic [CW-1:0] cnt_q;

    assign sat_o = (cnt_q >= CW'(LIMIT));
    assign cnt_o = cnt_q;

    // Count up while USB loses, stop at the limit, clear when USB wins or leaves.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && !sat_o) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: cart has priority, USB is protected from
// starvation, one read outstanding at a time with an abandon timeout.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | sampling requests, granting when the selected path is ready
//   ISSUE   | one-cycle command pulse and ack to the granted requester
//   RD_WAIT | waiting for mem_rvalid; timeout down-counter running
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned RD_TIMEOUT   = 1024
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        cart_req_i,
    input  logic        cart_we_i,
    input  logic [25:0] cart_addr_i,
    input  logic [1:0]  cart_width_i,
    input  logic [15:0] cart_wdata_i,
    output logic        cart_ack_o,
    output logic [15:0] cart_rdata_o,
    output logic        cart_rvalid_o,

    input  logic        usb_req_i,
    input  logic        usb_we_i,
    input  logic [25:0] usb_addr_i,
    input  logic [31:0] usb_wdata_i,
    output logic        usb_ack_o,
    output logic [31:0] usb_rdata_o,
    output logic        usb_rvalid_o,

    input  logic        mem_rd_ready_i,
    input  logic        mem_wr_ready_i,
    output logic        mem_rd_o,
    output logic        mem_wr_o,
    output logic [25:0] mem_addr_o,
    output logic [1:0]  mem_width_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_rvalid_i,

    output logic        timeout_err_o
);

    localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam int unsigned TW = (RD_TIMEOUT < 2) ? 1 : $clog2(RD_TIMEOUT);

    arb_state_e    state_q, state_d;
    req_id_e       id_q, id_d;
    logic          we_q, we_d;
    logic [25:0]   addr_q, addr_d;
    logic [1:0]    width_q, width_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic [SW-1:0] starve_cnt;
    logic          starved;
    logic          usb_grant;
    logic          sel_usb;
    logic          sel_we;
    logic          sel_ready;
    logic          rd_done;
    logic          rd_expired;
    logic [31:0]   rd_word;

    // USB goes first only when starved or when the cart is quiet.
    assign sel_usb   = usb_req_i && (starved || !cart_req_i);
    assign sel_we    = sel_usb ? usb_we_i : cart_we_i;
    assign sel_ready = sel_we ? mem_wr_ready_i : mem_rd_ready_i;

    assign rd_expired = (state_q == RD_WAIT) && (tmo_q == '0);
    assign rd_done    = (state_q == RD_WAIT) && (mem_rvalid_i || rd_expired);
    assign rd_word    = mem_rvalid_i ? mem_rdata_i : 32'hFFFF_FFFF;

    arb_starve_counter #(
        .LIMIT (STARVE_LIMIT),
        .CW    (SW)
    ) u_starve (
        .clk   (clk),
        .rst   (rst),
        .inc_i (state_q == IDLE && usb_req_i && !usb_grant),
        .clr_i (usb_grant || !usb_req_i),
        .cnt_o (starve_cnt),
        .sat_o (starved)
    );

    // State, granted-command and timeout registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            id_q    <= REQ_CART;
            we_q    <= 1'b0;
            addr_q  <= '0;
            width_q <= DATA_WIDTH_0;
            wdata_q <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            width_q <= width_d;
            wdata_q <= wdata_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next-state: grant in IDLE, fork on direction in ISSUE, finish or count down in RD_WAIT.
    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        we_d      = we_q;
        addr_d    = addr_q;
        width_d   = width_q;
        wdata_d   = wdata_q;
        tmo_d     = tmo_q;
        usb_grant = 1'b0;
        case (state_q)
            IDLE: begin
                // A stalled selection blocks the other requester on purpose.
                if ((cart_req_i || usb_req_i) && sel_ready) begin
                    state_d = ISSUE;
                    we_d    = sel_we;
                    if (sel_usb) begin
                        usb_grant = 1'b1;
                        id_d      = REQ_USB;
                        addr_d    = usb_addr_i;
                        width_d   = DATA_WIDTH_32;
                        wdata_d   = usb_wdata_i;
                    end else begin
                        id_d      = REQ_CART;
                        addr_d    = cart_addr_i;
                        width_d   = cart_width_i;
                        wdata_d   = {16'h0000, cart_wdata_i};
                    end
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = RD_WAIT;
                    tmo_d   = TW'(RD_TIMEOUT - 1);
                end
            end
            RD_WAIT: begin
                if (rd_done) begin
                    state_d = IDLE;
                    tmo_d   = '0;
                end else begin
                    tmo_d   = tmo_q - TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pulse outputs; forced low while rst is high so an abandoned read leaks nothing.
    always_comb begin
        cart_ack_o    = 1'b0;
        usb_ack_o     = 1'b0;
        mem_rd_o      = 1'b0;
        mem_wr_o      = 1'b0;
        cart_rvalid_o = 1'b0;
        usb_rvalid_o  = 1'b0;
        cart_rdata_o  = '0;
        usb_rdata_o   = '0;
        timeout_err_o = 1'b0;
        if (!rst) begin
            if (state_q == ISSUE) begin
                cart_ack_o = (id_q == REQ_CART);
                usb_ack_o  = (id_q == REQ_USB);
                mem_rd_o   = !we_q;
                mem_wr_o   = we_q;
            end
            if (rd_done) begin
                timeout_err_o = !mem_rvalid_i;
                if (id_q == REQ_CART) begin
                    cart_rvalid_o = 1'b1;
                    cart_rdata_o  = rd_word[15:0];
                end else begin
                    usb_rvalid_o  = 1'b1;
                    usb_rdata_o   = rd_word;
                end
            end
        end
    end

    assign mem_addr_o  = addr_q;
    assign mem_width_o = width_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table for the basic
// transactions plus hand sequences for starvation, timeouts and reset.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cart_req, cart_we, cart_ack, cart_rvalid;
    logic [25:0] cart_addr;
    logic [1:0]  cart_width;
    logic [15:0] cart_wdata, cart_rdata;
    logic        usb_req, usb_we, usb_ack, usb_rvalid;
    logic [25:0] usb_addr;
    logic [31:0] usb_wdata, usb_rdata;
    logic        mem_rd_ready, mem_wr_ready, mem_rd, mem_wr, mem_rvalid;
    logic [25:0] mem_addr;
    logic [1:0]  mem_width;
    logic [31:0] mem_wdata, mem_rdata;
    logic        timeout_err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .cart_req_i     (cart_req),
        .cart_we_i      (cart_we),
        .cart_addr_i    (cart_addr),
        .cart_width_i   (cart_width),
        .cart_wdata_i   (cart_wdata),
        .cart_ack_o     (cart_ack),
        .cart_rdata_o   (cart_rdata),
        .cart_rvalid_o  (cart_rvalid),
        .usb_req_i      (usb_req),
        .usb_we_i       (usb_we),
        .usb_addr_i     (usb_addr),
        .usb_wdata_i    (usb_wdata),
        .usb_ack_o      (usb_ack),
        .usb_rdata_o    (usb_rdata),
        .usb_rvalid_o   (usb_rvalid),
        .mem_rd_ready_i (mem_rd_ready),
        .mem_wr_ready_i (mem_wr_ready),
        .mem_rd_o       (mem_rd),
        .mem_wr_o       (mem_wr),
        .mem_addr_o     (mem_addr),
        .mem_width_o    (mem_width),
        .mem_wdata_o    (mem_wdata),
        .mem_rdata_i    (mem_rdata),
        .mem_rvalid_i   (mem_rvalid),
        .timeout_err_o  (timeout_err)
    );

    // {cart_ack, cart_rvalid, usb_ack, usb_rvalid, mem_rd, mem_wr, timeout_err}
    logic [6:0] pulses;
    assign pulses = {cart_ack, cart_rvalid, usb_ack, usb_rvalid, mem_rd, mem_wr, timeout_err};

    // in: {rst, cart_req, cart_we, usb_req, usb_we, rd_ready, wr_ready, mem_rvalid}
    // fsel: 0 = fields cleared, 1 = cart command, 2 = usb command
    typedef struct {
        logic [7:0] in;
        logic [6:0] exp;
        logic [1:0] fsel;
    } vec_t;

    vec_t vecs [19];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    function automatic logic [59:0] exp_fields(input logic [1:0] fsel);
        case (fsel)
            2'd1:    return {26'h0000100, 2'b10, 32'h0000_5A5A};
            2'd2:    return {26'h0000200, 2'b11, 32'hDEAD_BEEF};
            default: return 60'h0;
        endcase
    endfunction

    task automatic drive(input logic [7:0] in);
        {rst, cart_req, cart_we, usb_req, usb_we, mem_rd_ready, mem_wr_ready, mem_rvalid} = in;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cart_acks;
        int found_at;
        int extra;
        int early;
        logic [15:0] c_rd;
        logic [31:0] u_rd;
        logic t_err, u_rv;

        cart_addr  = 26'h0000100;
        cart_width = 2'b10;
        cart_wdata = 16'h5A5A;
        usb_addr   = 26'h0000200;
        usb_wdata  = 32'hDEAD_BEEF;
        mem_rdata  = 32'h1234_ABCD;
        drive(8'b1000_0000);
        step();
        step();

        vecs[0]  = '{8'b1000_0000, 7'b0000000, 2'd0};
        vecs[1]  = '{8'b0000_0000, 7'b0000000, 2'd0};
        vecs[2]  = '{8'b0100_0110, 7'b0000000, 2'd0};
        vecs[3]  = '{8'b0000_0110, 7'b1000100, 2'd1};
        vecs[4]  = '{8'b0000_0110, 7'b0000000, 2'd1};
        vecs[5]  = '{8'b0000_0110, 7'b0000000, 2'd1};
        vecs[6]  = '{8'b0000_0111, 7'b0100000, 2'd1};
        vecs[7]  = '{8'b0000_0111, 7'b0000000, 2'd1};
        vecs[8]  = '{8'b0001_1110, 7'b0000000, 2'd1};
        vecs[9]  = '{8'b0000_0110, 7'b0010010, 2'd2};
        vecs[10] = '{8'b0110_0110, 7'b0000000, 2'd2};
        vecs[11] = '{8'b0000_0110, 7'b1000010, 2'd1};
        vecs[12] = '{8'b0111_0100, 7'b0000000, 2'd1};
        vecs[13] = '{8'b0111_0100, 7'b0000000, 2'd1};
        vecs[14] = '{8'b0111_0110, 7'b0000000, 2'd1};
        vecs[15] = '{8'b0001_0110, 7'b1000010, 2'd1};
        vecs[16] = '{8'b0001_0110, 7'b0000000, 2'd1};
        vecs[17] = '{8'b0000_0110, 7'b0010100, 2'd2};
        vecs[18] = '{8'b0000_0111, 7'b0001000, 2'd2};

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].in);
            @(negedge clk);
            check($sformatf("vec%0d_pulses", i), {121'h0, pulses}, {121'h0, vecs[i].exp});
            check($sformatf("vec%0d_data", i),
                  {20'h0, mem_addr, mem_width, mem_wdata, cart_rdata, usb_rdata},
                  {20'h0, exp_fields(vecs[i].fsel),
                   (vecs[i].exp[5] ? 16'hABCD : 16'h0000),
                   (vecs[i].exp[3] ? 32'h1234_ABCD : 32'h0)});
            step();
        end

        // Starvation: cart writes back to back, USB write pending the whole time.
        drive(8'b0111_1110);
        cart_acks = 0;
        found_at  = -1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (cart_ack) cart_acks++;
            if (usb_ack) begin
                found_at = c;
                break;
            end
            step();
        end
        check("starve_usb_granted", {127'h0, found_at >= 0}, 128'h1);
        check("starve_cart_grants", 128'(cart_acks), 128'd8);
        check("starve_cnt_cleared", 128'(dut.starve_cnt), 128'd0);
        check("starve_usb_width", {126'h0, mem_width}, 128'h3);
        step();
        drive(8'b0000_0110);
        step();

        // Cart read that never returns data.
        drive(8'b0100_0110);
        step();
        drive(8'b0000_0110);
        @(negedge clk);
        check("tmo_cart_issue", {121'h0, pulses}, {121'h0, 7'b1000100});
        found_at = -1;
        for (int c = 1; c <= 1100; c++) begin
            step();
            @(negedge clk);
            if (cart_rvalid || timeout_err || usb_rvalid) begin
                found_at = c;
                break;
            end
        end
        check("tmo_cart_latency", 128'(found_at), 128'd1024);
        check("tmo_cart_result", {110'h0, cart_rdata, cart_rvalid, timeout_err, usb_rvalid},
              {110'h0, 16'hFFFF, 1'b1, 1'b1, 1'b0});
        extra = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            @(negedge clk);
            if (cart_rvalid || timeout_err || usb_rvalid) extra++;
        end
        check("tmo_cart_single_pulse", 128'(extra), 128'd0);
        step();

        // USB read whose data lands on the exact timeout cycle: data wins.
        drive(8'b0001_0110);
        step();
        drive(8'b0000_0110);
        @(negedge clk);
        check("race_usb_issue", {121'h0, pulses}, {121'h0, 7'b0010100});
        early = 0;
        u_rv  = 1'b0;
        u_rd  = '0;
        t_err = 1'b0;
        for (int c = 1; c <= 1024; c++) begin
            step();
            mem_rvalid = (c == 1024);
            @(negedge clk);
            if (c < 1024 && (usb_rvalid || timeout_err || cart_rvalid)) early++;
            if (c == 1024) begin
                u_rv  = usb_rvalid;
                u_rd  = usb_rdata;
                t_err = timeout_err;
            end
        end
        check("race_no_early", 128'(early), 128'd0);
        check("race_data_wins", {94'h0, u_rv, t_err, u_rd}, {94'h0, 1'b1, 1'b0, 32'h1234_ABCD});
        step();
        mem_rvalid = 1'b0;
        @(negedge clk);
        check("race_back_idle", {121'h0, pulses}, 128'h0);

        // Reset two cycles into RD_WAIT, with and after a late mem_rvalid.
        step();
        drive(8'b0100_0110);
        step();
        drive(8'b0000_0110);
        @(negedge clk);
        check("rst_rd_issue", {121'h0, pulses}, {121'h0, 7'b1000100});
        step();
        @(negedge clk);
        step();
        drive(8'b1000_0111);
        @(negedge clk);
        c_rd = cart_rdata;
        check("rst_during_rvalid", {105'h0, pulses, c_rd}, 128'h0);
        step();
        drive(8'b0000_0111);
        @(negedge clk);
        check("rst_late_rvalid", {1'b0, pulses, mem_addr, mem_width, mem_wdata, cart_rdata, usb_rdata},
              128'h0);
        step();
        drive(8'b0000_0000);
        @(negedge clk);
        check("rst_idle_after", {121'h0, pulses}, 128'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 8, consecutive cycles a pending USB request may lose to cart before USB is forced ahead.
REQ-002 Parameter RD_TIMEOUT, default 1024, cycles allowed in RD_WAIT before the read is abandoned.
REQ-003 Reset rst, synchronous, active-high; clock clk.
REQ-004 clk  in  1  system clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 cart_req  in  1  cart request pending, held until cart_ack.
REQ-007 cart_we  in  1  1 = write, 0 = read.
REQ-008 cart_addr  in  26  byte address.
REQ-009 cart_width  in  2  access width code (00 none, 01 8-bit, 10 16-bit, 11 32-bit).
REQ-010 cart_wdata  in  16  write data, zero-extended to 32 on mem_wdata.
REQ-011 cart_ack  out  1  one-cycle accept pulse.
REQ-012 cart_rdata  out  16  read data, equal to mem_rdata[15:0].
REQ-013 cart_rvalid  out  1  one-cycle read-data-valid pulse.
REQ-014 usb_req, usb_we, usb_addr[26], usb_wdata[32], usb_ack, usb_rdata[32], usb_rvalid: same meaning as the cart set, 32-bit data, width always 11.
REQ-015 mem_rd_ready, mem_wr_ready  in  1 each  memory can accept read / write.
REQ-016 mem_rd, mem_wr  out  1 each  one-cycle command pulses.
REQ-017 mem_addr out 26, mem_width out 2, mem_wdata out 32  command fields, registered, held until the next command.
REQ-018 mem_rdata  in  32, mem_rvalid  in  1  read return.
REQ-019 timeout_err  out  1  one-cycle pulse when a read is abandoned.

Function
REQ-020 States: IDLE, ISSUE, RD_WAIT; no other states are reachable.
REQ-021 Selection in IDLE: USB if usb_req and starve_cnt >= STARVE_LIMIT; else cart if cart_req; else USB if usb_req.
REQ-022 The grant is taken only if the selected requester's ready is high (mem_rd_ready for reads, mem_wr_ready for writes); otherwise the FSM stays in IDLE and does not fall through to the other requester.
REQ-023 Grant at edge N: in cycle N+1 the FSM is in ISSUE, mem_rd or mem_wr = 1, command fields are loaded, and the requester's ack = 1.
REQ-024 Requests are not sampled in ISSUE or RD_WAIT; the requester drops or changes req in the cycle after ack.
REQ-025 Write path: ISSUE -> IDLE; minimum 2 cycles per write.
REQ-026 Read path: ISSUE -> RD_WAIT; on mem_rvalid, rdata routes to the issuing requester only, its rvalid pulses in the same cycle, and the FSM returns to IDLE.
REQ-027 Only one outstanding read at a time; mem_rvalid seen outside RD_WAIT is ignored.
REQ-028 Read timeout: a cycle counter runs in RD_WAIT. On reaching RD_TIMEOUT, the issuing requester's rvalid pulses with rdata all ones, timeout_err pulses, and the FSM goes to IDLE.
REQ-029 mem_rvalid in the same cycle as the timeout: the real data wins and timeout_err stays 0.
REQ-030 starve_cnt increments each IDLE cycle with usb_req high and no USB grant, saturates at STARVE_LIMIT, and clears on USB grant or when usb_req is low.
REQ-031 Simultaneous cart and USB requests with starve_cnt < STARVE_LIMIT: cart wins.

Reset
REQ-032 On rst: state = IDLE; all outputs 0; mem_addr/mem_width/mem_wdata = 0; starve_cnt and timeout counter = 0.
REQ-033 rst during RD_WAIT abandons the read: no rvalid and no timeout_err is produced, and a late mem_rvalid is ignored.

Structure
REQ-034 A shared package holds the data-width codes (DATA_WIDTH_0/8/16/32), the FSM state enum, and a requester-id enum (REQ_CART, REQ_USB).
REQ-035 One sub-module, arb_starve_counter, implements the saturating starvation counter.

Verification
REQ-036 Cart read at addr 0x0000100 with mem_rvalid 3 cycles after mem_rd and mem_rdata 0x1234ABCD -> cart_ack at N+1, cart_rdata 0xABCD with cart_rvalid 1 cycle, usb_rvalid stays 0.
REQ-037 USB write 0xDEADBEEF to addr 0x0000200 -> mem_wr 1 cycle, mem_width 11, usb_ack, IDLE 2 cycles after grant.
REQ-038 Cart held continuously requesting while USB requests -> USB is granted at the latest after 8 cart grants, and starve_cnt returns to 0.
REQ-039 Read with mem_rvalid never asserted -> after 1024 cycles, requester rdata 0xFFFFFFFF (cart 0xFFFF), rvalid and timeout_err each pulse once.
REQ-040 Cart write selected with mem_wr_ready = 0 and mem_rd_ready = 1 while a USB read is pending -> no grant to either requester until mem_wr_ready rises, then the cart write is granted.
REQ-041 rst asserted 2 cycles into RD_WAIT, then mem_rvalid -> all outputs 0, no rvalid pulse.
